// File: rtl/rca_pkg.sv
// Shared segmentation helpers for the pipelined ripple-carry adder and the multiplier top.
package rca_pkg;

   localparam int unsigned WIDTH_A_DEF     = 10;
   localparam int unsigned WIDTH_B_DEF     = 11;
   localparam int unsigned STAGES_DEF      = 2;
   localparam int unsigned APPROX_BITS_DEF = 4;

   // Segment width: ceil(width_b / stages).
   function automatic int unsigned seg_width(input int unsigned width_b, input int unsigned stages);
      return (width_b + stages - 1) / stages;
   endfunction

   localparam int unsigned SEG = seg_width(WIDTH_B_DEF, STAGES_DEF);

   function automatic int unsigned seg_lo(input int unsigned k, input int unsigned seg = SEG);
      return k * seg;
   endfunction

   // Width of segment k; the last segment takes the remainder and may be empty.
   function automatic int unsigned seg_len(input int unsigned k, input int unsigned seg,
                                           input int unsigned width_b);
      int unsigned lo;
      lo = k * seg;
      if (lo >= width_b) return 0;
      return ((width_b - lo) < seg) ? (width_b - lo) : seg;
   endfunction

endpackage

// File: rtl/rca_pipe_adder_seg.sv
// Combinational W-bit ripple-carry segment built from full-adder equations.
module rca_seg #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_ci,
   output logic [W-1:0] o_sum_c,
   output logic         o_co_c
);

   logic [W:0] w_c;

   assign w_c[0] = i_ci;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign o_sum_c[i] = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_co_c = w_c[W];

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder with valid/ready on both sides, carry chain split into STAGES segments.
// Define RCA_APPROX_LSB_EN for the carry-free approximate low part (APPROX_BITS wide).
module rca_pipe_adder
   import rca_pkg::*;
#(
   parameter int unsigned WIDTH_A     = WIDTH_A_DEF,
   parameter int unsigned WIDTH_B     = WIDTH_B_DEF,
   parameter int unsigned STAGES      = STAGES_DEF,
   parameter int unsigned APPROX_BITS = APPROX_BITS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_A-1:0] a,
   input  logic [WIDTH_B-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_B-1:0] sum,
   output logic               cout
);

   localparam int unsigned N     = WIDTH_B;
   localparam int unsigned S     = STAGES;
   localparam int unsigned SEG_W = seg_width(WIDTH_B, STAGES);

   if (WIDTH_A > WIDTH_B || STAGES == 0 || STAGES > WIDTH_B || APPROX_BITS >= WIDTH_B) begin : g_bad_cfg
      $error("rca_pipe_adder: unsupported parameter set");
   end

   logic [N-1:0] w_a_ext;
   logic [N-1:0] w_a0;
   logic [N-1:0] w_b0;

   logic [N-1:0] r_a [S];
   logic [N-1:0] r_b [S];
   logic [N-1:0] r_s [S];
   logic         r_c [S];
   logic [S-1:0] r_v;

   logic [N-1:0] w_a_in  [S];
   logic [N-1:0] w_b_in  [S];
   logic [N-1:0] w_s_nxt [S];
   logic         w_c_nxt [S];
   logic [S-1:0] w_v_in;
   logic [S-1:0] w_adv;

   assign w_a_ext = N'(a);

`ifdef RCA_APPROX_LSB_EN
   // Low part moves into b with a zeroed there, so the exact chain adds it carry-free.
   localparam logic [N-1:0] LOW_MASK = (N'(1) << APPROX_BITS) - N'(1);

   logic [N-1:0] w_low;
   logic         w_hit;

   always_comb begin
      w_low = '0;
      w_hit = 1'b0;
      for (int i = int'(APPROX_BITS) - 1; i >= 0; i--) begin
         if (w_hit || (w_a_ext[i] && b[i])) begin
            w_low[i] = 1'b1;
            w_hit    = 1'b1;
         end else begin
            w_low[i] = w_a_ext[i] ^ b[i];
         end
      end
   end

   assign w_a0 = w_a_ext & ~LOW_MASK;
   assign w_b0 = (b & ~LOW_MASK) | w_low;
`else
   assign w_a0 = w_a_ext;
   assign w_b0 = b;
`endif

   // Stage k loads when it is empty or everything downstream of it is moving.
   always_comb begin
      logic w_acc;
      w_adv = '0;
      w_acc = out_ready;
      for (int k = int'(S) - 1; k >= 0; k--) begin
         w_acc    = w_acc | ~r_v[k];
         w_adv[k] = w_acc;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_stg
      localparam int unsigned LO = seg_lo(k, SEG_W);
      localparam int unsigned W  = seg_len(k, SEG_W, N);

      logic [N-1:0] w_s_i;
      logic         w_c_i;

      if (k == 0) begin : g_first
         assign w_a_in[k] = w_a0;
         assign w_b_in[k] = w_b0;
         assign w_s_i     = '0;
         assign w_c_i     = 1'b0;
         assign w_v_in[k] = in_valid;
      end else begin : g_next
         assign w_a_in[k] = r_a[k-1];
         assign w_b_in[k] = r_b[k-1];
         assign w_s_i     = r_s[k-1];
         assign w_c_i     = r_c[k-1];
         assign w_v_in[k] = r_v[k-1];
      end

      if (W > 0) begin : g_add
         localparam logic [N-1:0] MASK = ((N'(1) << W) - N'(1)) << LO;

         logic [W-1:0] w_seg;
         logic         w_co;

         rca_seg #(.W(W)) u_seg (
            .i_a     (w_a_in[k][LO +: W]),
            .i_b     (w_b_in[k][LO +: W]),
            .i_ci    (w_c_i),
            .o_sum_c (w_seg),
            .o_co_c  (w_co)
         );

         assign w_s_nxt[k] = (w_s_i & ~MASK) | (N'(w_seg) << LO);
         assign w_c_nxt[k] = w_co;
      end else begin : g_pass
         assign w_s_nxt[k] = w_s_i;
         assign w_c_nxt[k] = w_c_i;
      end
   end

   // Data only loads with a valid item so the output holds its last value when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v <= '0;
         for (int k = 0; k < int'(S); k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < int'(S); k++) begin
            if (w_adv[k]) begin
               r_v[k] <= w_v_in[k];
               if (w_v_in[k]) begin
                  r_a[k] <= w_a_in[k];
                  r_b[k] <= w_b_in[k];
                  r_s[k] <= w_s_nxt[k];
                  r_c[k] <= w_c_nxt[k];
               end
            end
         end
      end
   end

   assign in_ready  = w_adv[0];
   assign out_valid = r_v[S-1];
   assign sum       = r_s[S-1];
   assign cout      = r_c[S-1];

endmodule
